// File: rtl/trace_capture_if.sv
// trace_capture_if: core-side trace strobes plus the record output stream and status
interface trace_capture_if #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
);
    logic                       enable;
    logic                       reg_write_sig;
    logic [4:0]                 reg_num;
    logic [31:0]                reg_data;
    logic                       wr;
    logic                       rd;
    logic [8:0]                 addr;
    logic [31:0]                wr_data;
    logic [31:0]                rd_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [1:0]                 out_type;
    logic [8:0]                 out_index;
    logic [31:0]                out_data;
    logic [TS_W-1:0]            out_ts;
    logic [$clog2(DEPTH):0]     count;
    logic [15:0]                drop_cnt;
    logic                       overflow;

    modport master (
        output enable, reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, out_ready,
        input  out_valid, out_type, out_index, out_data, out_ts, count, drop_cnt, overflow
    );

    modport slave (
        input  enable, reg_write_sig, reg_num, reg_data, wr, rd, addr, wr_data, rd_data, out_ready,
        output out_valid, out_type, out_index, out_data, out_ts, count, drop_cnt, overflow
    );
endinterface

// File: rtl/trace_capture.sv
// trace_capture: timestamped commit-trace FIFO for reg-write/mem events; TRACE_FILTER_X0_EN drops x0 writes
module trace_capture #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 16
) (
    input logic           clk,
    input logic           reset,
    trace_capture_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = 2 + 9 + 32 + TS_W;

    logic [TS_W-1:0] ts;
    logic [AW-1:0]   wp;
    logic [AW-1:0]   rp;
    logic [CW-1:0]   cnt;
    logic [15:0]     drop_q;
    logic            ovf;
    logic [RW-1:0]   mem [DEPTH];

    logic            reg_ev;
    logic            mem_ev;
    logic [1:0]      n_ev;
    logic [1:0]      pushes;
    logic [1:0]      drops;
    logic [CW-1:0]   free;
    logic            valid;
    logic            pop;
    logic [16:0]     drop_sum;
    logic [RW-1:0]   reg_rec;
    logic [RW-1:0]   mem_rec;
    logic [RW-1:0]   first_rec;
    logic [RW-1:0]   head;

`ifdef TRACE_FILTER_X0_EN
    assign reg_ev = bus.enable && bus.reg_write_sig && (bus.reg_num != 5'd0);
`else
    assign reg_ev = bus.enable && bus.reg_write_sig;
`endif
    // wr and rd together is an illegal access and is silently ignored
    assign mem_ev = bus.enable && (bus.wr ^ bus.rd);

    assign reg_rec   = {2'b01, 4'b0000, bus.reg_num, bus.reg_data, ts};
    assign mem_rec   = {bus.wr ? 2'b10 : 2'b11, bus.addr, bus.wr ? bus.wr_data : bus.rd_data, ts};
    assign first_rec = reg_ev ? reg_rec : mem_rec;

    // Free space is taken before the pop, so a same-cycle pop never makes room
    assign n_ev     = {1'b0, reg_ev} + {1'b0, mem_ev};
    assign free     = CW'(DEPTH) - cnt;
    assign pushes   = (free >= CW'(n_ev)) ? n_ev : free[1:0];
    assign drops    = n_ev - pushes;
    assign drop_sum = {1'b0, drop_q} + 17'(drops);

    assign valid = (cnt != '0);
    assign pop   = valid && bus.out_ready;
    assign head  = mem[rp];

    assign bus.out_valid = valid;
    assign bus.out_type  = valid ? head[RW-1:RW-2] : '0;
    assign bus.out_index = valid ? head[RW-3:RW-11] : '0;
    assign bus.out_data  = valid ? head[TS_W+31:TS_W] : '0;
    assign bus.out_ts    = valid ? head[TS_W-1:0] : '0;
    assign bus.count     = cnt;
    assign bus.drop_cnt  = drop_q;
    assign bus.overflow  = ovf;

    // Pointers, occupancy, free-running timestamp and drop accounting
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts     <= '0;
            wp     <= '0;
            rp     <= '0;
            cnt    <= '0;
            drop_q <= '0;
            ovf    <= 1'b0;
        end else begin
            ts     <= ts + TS_W'(1);
            wp     <= wp + AW'(pushes);
            rp     <= rp + AW'(pop);
            cnt    <= cnt + CW'(pushes) - CW'(pop);
            drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            ovf    <= ovf || (drops != 2'd0);
        end
    end

    // Record storage; the first slot takes the priority event, the second is always the mem event
    always_ff @(posedge clk) begin
        if (pushes != 2'd0) mem[wp] <= first_rec;
        if (pushes == 2'd2) mem[wp + AW'(1)] <= mem_rec;
    end
endmodule

// File: doc/trace_capture.md
# trace_capture

Hardware commit-trace buffer sitting directly downstream of the `riscv` core's debug/trace outputs. Each cycle it samples the core's register-write and data-memory access strobes and packs every event into a timestamped record. Records go into a DEPTH-entry FIFO and are drained through a valid/ready stream toward an on-chip logger or debug port. It is the synthesizable counterpart of the simulation-only register/memory `$display` monitoring.

## Interface
- DEPTH, 16: FIFO entries; power of two, ≥ 2.
- TS_W, 16: timestamp width in bits.

- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  capture enable; sampled each cycle.
- reg_write_sig  in  1  core register-file write strobe.
- reg_num  in  5  destination register index.
- reg_data  in  32  value written to the register.
- wr  in  1  data-memory write strobe.
- rd  in  1  data-memory read strobe.
- addr  in  9  data-memory word address.
- wr_data  in  32  memory write data.
- rd_data  in  32  memory read data.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts the head record.
- out_type  out  2  record type: 01 = reg write, 10 = mem write, 11 = mem read.
- out_index  out  9  reg: {4'b0, reg_num}; mem: addr.
- out_data  out  32  reg_data, wr_data or rd_data.
- out_ts  out  TS_W  timestamp at capture.
- count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- drop_cnt  out  16  dropped-event counter; saturates at 16'hFFFF.
- overflow  out  1  sticky; set on the first dropped event.

## Operation
- Timestamp counter: free-running, increments every cycle regardless of enable, wraps modulo 2^TS_W.
- Event detection, only when enable = 1:
  - Reg event: reg_write_sig = 1.
  - Mem event: wr ^ rd. wr = rd = 1 is illegal and is ignored; it is neither recorded nor counted as a drop.
- Up to two events per cycle. The reg event always takes priority and occupies the first slot; the mem event takes the second slot.
- Free space = DEPTH − count, evaluated before this cycle's pop. A pop does not create room for a same-cycle push.
  - free ≥ 2: both events written; reg record first, mem record second in FIFO order.
  - free = 1: the first-priority event is written; the other is dropped.
  - free = 0: all events this cycle are dropped.
- Each dropped event increments drop_cnt by 1 (saturating) and sets overflow. overflow clears only on reset.
- Pop occurs when out_valid && out_ready.
- count update per cycle: count_next = count + pushes − pop.
- out_* present the head entry whenever out_valid = 1; they hold stable until popped. Their values are don't-care while out_valid = 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset values: out_valid 0, count 0, drop_cnt 0, overflow 0, timestamp 0, read/write pointers 0. out_type/out_index/out_data/out_ts reset to 0.
- Latency: an event sampled at edge N is visible at out_valid/out_* after edge N (one-cycle latency). out_ts equals the timestamp value during cycle N.
- A dual event at edge N with an empty FIFO and out_ready held 1: reg record at head after N, mem record at head after N+1.
- Throughput: one pop per cycle. out_valid is derived combinationally from count ≠ 0, with no bubble between records.
- Asserting reset mid-stream flushes the FIFO immediately, independent of clk; records in flight are lost.
- A deasserted enable takes effect in the same cycle it is sampled. Records already queued continue to drain.

## Configuration
- TRACE_FILTER_X0_EN defined: reg events with reg_num = 0 are discarded before slot allocation. They are neither stored nor counted as drops, and a same-cycle mem event takes the first slot.
- TRACE_FILTER_X0_EN undefined: writes to x0 are recorded like any other register.

## Test plan
- Single reg write x5 = 32'h0000_002A at ts 7, out_ready = 1 -> one record: type 01, index 5, data 32'h2A, ts 7; count returns to 0.
- Same cycle: reg write x1 = 32'hFFFF_FFFF and mem write addr 9'd12 = 32'h1234_5678 -> two records in order: type 01 first, then type 10 with index 12.
- out_ready = 0, DEPTH = 16: 15 reg writes, then one cycle with a reg write plus a mem read -> count 16, drop_cnt 1, overflow 1; the reg event is kept and the mem event is dropped.
- wr = rd = 1 with addr 9'd3 -> no record, drop_cnt unchanged; with enable = 0 a reg write yields no record while out_ts of later records still reflects the elapsed cycles.
- With TRACE_FILTER_X0_EN, reg write x0 plus mem read addr 9'd4 = 32'hCAFE -> exactly one record, type 11, index 4. Without the macro, two records are produced.
- Reset asserted asynchronously with count = 6 mid-drain -> out_valid 0, count 0, drop_cnt 0, overflow 0 before the next clk edge.
